// File: rtl/arm_instr_encoder.sv
// Program loader: packs decoded DP/LDR/STR/B fields into ARM words and streams them into imem.
// Optional ENC_READBACK_EN adds a read-back/compare pass after every write.
module arm_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 64,
  localparam int         COUNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_class,
  input  logic [3:0]         in_cond,
  input  logic [1:0]         in_cmd,
  input  logic               in_s,
  input  logic [3:0]         in_rn,
  input  logic [3:0]         in_rd,
  input  logic [23:0]        in_imm,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic [COUNT_W-1:0] word_count,
  output logic               full,
  output logic               err_illegal,
  output logic               err_mismatch
);

  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

`ifdef ENC_READBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RDBK, S_CMP, S_FULL} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_FULL} state_t;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_word;
  logic [COUNT_W-1:0] r_count;
  logic               r_err_illegal;
  logic               r_err_mismatch;

  logic [31:0]        w_encoded;
  logic               w_legal;
  logic [3:0]         w_cmd4;
  logic [COUNT_W-1:0] w_count_inc;
  logic [COUNT_W-1:0] w_addr_idx;

  assign w_count_inc = r_count + 1'b1;

  always_comb begin
    case (in_cmd)
      2'b00:   w_cmd4 = 4'b0100;
      2'b01:   w_cmd4 = 4'b0010;
      2'b10:   w_cmd4 = 4'b0000;
      default: w_cmd4 = 4'b1100;
    endcase
  end

  always_comb begin
    w_legal   = 1'b1;
    w_encoded = 32'h0;
    case (in_class)
      3'b000:  w_encoded = {in_cond, 2'b00, 1'b1, w_cmd4, in_s, in_rn, in_rd, in_imm[11:0]};
      3'b001:  w_encoded = {in_cond, 2'b00, 1'b0, w_cmd4, in_s, in_rn, in_rd, 8'h00, in_imm[3:0]};
      3'b010:  w_encoded = {in_cond, 2'b01, 6'b011001, in_rn, in_rd, in_imm[11:0]};
      3'b011:  w_encoded = {in_cond, 2'b01, 6'b011000, in_rn, in_rd, in_imm[11:0]};
      3'b100:  w_encoded = {in_cond, 2'b10, 2'b10, in_imm};
      default: w_legal   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid && w_legal) w_state_next = S_WRITE;
`ifdef ENC_READBACK_EN
        S_WRITE: w_state_next = S_RDBK;
        S_RDBK:  w_state_next = S_CMP;
        S_CMP:   w_state_next = (r_count == DEPTH_C) ? S_FULL : S_IDLE;
`else
        S_WRITE: w_state_next = (w_count_inc == DEPTH_C) ? S_FULL : S_IDLE;
`endif
        S_FULL:  w_state_next = S_FULL;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Count has already advanced by the read-back cycles, so step back one word there.
  always_comb begin
    in_ready   = (r_state == S_IDLE);
    mem_we     = (r_state == S_WRITE) && !clear;
    w_addr_idx = r_count;
`ifdef ENC_READBACK_EN
    if (r_state == S_RDBK || r_state == S_CMP) w_addr_idx = r_count - 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word         <= 32'h0;
      r_count        <= '0;
      r_err_illegal  <= 1'b0;
      r_err_mismatch <= 1'b0;
    end else if (clear) begin
      r_word         <= 32'h0;
      r_count        <= '0;
      r_err_illegal  <= 1'b0;
      r_err_mismatch <= 1'b0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        if (w_legal) r_word <= w_encoded;
        else         r_err_illegal <= 1'b1;
      end
      if (r_state == S_WRITE) r_count <= w_count_inc;
`ifdef ENC_READBACK_EN
      if (r_state == S_CMP && mem_rdata != r_word) r_err_mismatch <= 1'b1;
`endif
    end
  end

`ifndef ENC_READBACK_EN
  logic w_unused_rdata;
  assign w_unused_rdata = ^mem_rdata;
`endif

  assign mem_addr     = BASE_ADDR + (32'(w_addr_idx) << 2);
  assign mem_wdata    = r_word;
  assign word_count   = r_count;
  assign full         = (r_count == DEPTH_C);
  assign err_illegal  = r_err_illegal;
  assign err_mismatch = r_err_mismatch;

endmodule

// File: doc/arm_instr_encoder.md
# arm_instr_encoder

- Builds ARM machine words from decoded fields: class, condition, ALU command, S bit, registers, immediate.
- Writes each word sequentially into instruction memory through a valid/ready front end and a small write FSM.
- Produces exactly the DP/LDR/STR/B subset the datapath control decoder understands; it is that decoder's inverse, used as the program loader in front of imem.

## Interface
- BASE_ADDR, 32'h0: byte address of first word written
- DEPTH, 64: max words stored before full; COUNT_W = $clog2(DEPTH+1)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous restart: count to 0, errors cleared
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- in_class  in  3  000 DP-imm, 001 DP-reg, 010 LDR, 011 STR, 100 B, 101–111 illegal
- in_cond  in  4  condition field
- in_cmd  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- in_s  in  1  set-flags bit (DP only)
- in_rn, in_rd  in  4 each  register fields
- in_imm  in  24  DP-imm [11:0]; DP-reg Rm [3:0]; LDR/STR offset [11:0]; B offset [23:0]
- mem_we  out  1  imem write strobe
- mem_addr  out  32  BASE_ADDR + 4*word_count
- mem_wdata  out  32  encoded word
- mem_rdata  in  32  imem read data, 1-cycle synchronous latency (used only with readback)
- word_count  out  COUNT_W  words written
- full  out  1  word_count == DEPTH
- err_illegal  out  1  sticky, illegal class accepted
- err_mismatch  out  1  sticky, readback mismatch (0 without macro)

## Operation
- Encodings; cmd4 is ADD=0100, SUB=0010, AND=0000, ORR=1100:
  - DP-imm: {cond,00,1,cmd4,S,Rn,Rd,imm[11:0]}
  - DP-reg: {cond,00,0,cmd4,S,Rn,Rd,8'h00,imm[3:0]}
  - LDR: {cond,01,011001,Rn,Rd,imm[11:0]}
  - STR: {cond,01,011000,Rn,Rd,imm[11:0]}
  - B: {cond,10,10,imm[23:0]}
  - Unused in_imm bits and in_s for non-DP classes are ignored.
- FSM states: IDLE, WRITE, RDBK, CMP (RDBK and CMP exist only with macro), FULL.
- IDLE:
  - Handshake is in_valid & in_ready.
  - Legal class: register encoded word into word_q, go to WRITE.
  - Illegal class: set err_illegal, stay in IDLE; no write, count unchanged.
- WRITE: mem_we=1, mem_wdata=word_q, mem_addr from current count; word_count increments at cycle end.
  - Without macro: go to FULL if the new count == DEPTH, else IDLE.
- FULL: in_ready=0; left only by clear or reset.
- clear has priority over everything in every state:
  - mem_we forced 0 that cycle; word_q discarded.
  - count, err_illegal and err_mismatch go to 0; next state IDLE.
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_wdata=0, word_count=0, mem_addr=BASE_ADDR, full=0, both errors 0.
- mem_addr wraps modulo 2^32; no other arithmetic can overflow since count saturates at DEPTH.

## Timing
- Accept at edge N, write strobe during cycle N+1, in_ready high again in cycle N+2; throughput is 1 word per 2 cycles.
- With readback, 1 word per 4 cycles.
- in_ready depends only on state, never combinationally on in_valid.
- Holding in_valid high in IDLE gives back-to-back accepts, each separated by the write cycle(s).
- reset_n low at any point, including mid-WRITE, immediately drops mem_we to 0 and restores reset values.

## Configuration
- ENC_READBACK_EN defined: WRITE → RDBK → CMP.
  - RDBK drives mem_we=0 and the same mem_addr as the write.
  - CMP compares mem_rdata with word_q; mismatch sets err_mismatch.
  - Count increments at the end of WRITE as without the macro; the FULL/IDLE decision moves from WRITE to CMP.
- Undefined: RDBK/CMP absent, err_mismatch tied 0, mem_rdata unused.

## Test plan
- Reset, then DP-imm cond E, ADD, S=0, Rn=2, Rd=1, imm=5:
  - cycle after accept: mem_we=1, addr 0x0, data 0xE2821005
  - after that cycle: word_count=1
- Back-to-back, each after the previous:
  - DP-reg SUBS Rn=4, Rd=4, Rm=5 → 0xE0544005 at 0x4
  - LDR Rn=0, Rd=3, imm=8 → 0xE5903008 at 0x8
  - B cond E imm=2 → 0xEA000002 at 0xC
- DEPTH=4: after 4 writes, full=1 and in_ready=0; a fifth in_valid produces no write; clear → addr 0x0, full=0, in_ready=1.
- in_class=101 → accepted, err_illegal=1, no mem_we, count unchanged; next clear drops err_illegal to 0.
- Assert clear in the WRITE cycle → mem_we=0, count stays 0, IDLE next cycle. Assert reset_n low mid-WRITE → mem_we falls immediately.
- ENC_READBACK_EN: memory model corrupts bit 0 on readback → err_mismatch=1 in CMP; a correct model keeps it 0, and in_ready returns 4 cycles after accept.
